// File: rtl/gray_counter.sv
// Parametrised up/down counter with registered binary and Gray outputs.
// Supports parallel load, enable, wrap or saturate at the limits and a terminal-count pulse.
module gray_counter #(
  parameter int unsigned WIDTH = 3,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] Max = '1;
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             tc_d;

  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up) begin
        if (bin_q == Max) begin
          tc_d  = 1'b1;
          bin_d = WRAP ? '0 : Max;
        end else begin
          bin_d = bin_q + One;
        end
      end else begin
        if (bin_q == '0) begin
          tc_d  = 1'b1;
          bin_d = WRAP ? Max : '0;
        end else begin
          bin_d = bin_q - One;
        end
      end
    end
  end

  // Gray is derived from the next binary value so both registers always agree.
  assign gray_d = bin_d ^ (bin_d >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q    <= '0;
      gray_q   <= '0;
      tc_pulse <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      tc_pulse <= tc_d;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed scenarios plus a random soak,
// all instances checked every cycle against an arithmetic reference model.
module tb_gray_counter;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [31:0] load_val;

  logic [2:0] b3, g3;
  logic [3:0] b4, g4;
  logic [7:0] b8, g8;
  logic [4:0] b5w, g5w, b5s, g5s;
  logic       t3, t4, t8, t5w, t5s;

  int tests = 0;
  int fails = 0;

  // Reference state: expected binary count and pulse per instance.
  int  m3, m4, m8, m5w, m5s;
  bit  e3, e4, e8, e5w, e5s;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(3), .WRAP(1'b1)) u3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[2:0]),
    .bin_q(b3), .gray_q(g3), .tc_pulse(t3));
  gray_counter #(.WIDTH(4), .WRAP(1'b0)) u4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
    .bin_q(b4), .gray_q(g4), .tc_pulse(t4));
  gray_counter #(.WIDTH(8), .WRAP(1'b1)) u8 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[7:0]),
    .bin_q(b8), .gray_q(g8), .tc_pulse(t8));
  gray_counter #(.WIDTH(5), .WRAP(1'b1)) u5w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[4:0]),
    .bin_q(b5w), .gray_q(g5w), .tc_pulse(t5w));
  gray_counter #(.WIDTH(5), .WRAP(1'b0)) u5s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[4:0]),
    .bin_q(b5s), .gray_q(g5s), .tc_pulse(t5s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next-state rule from the behavioural description: plain integer arithmetic.
  task automatic model(inout int b, output bit tc, input int w, input bit wrap);
    int mx;
    mx = (1 << w) - 1;
    tc = 1'b0;
    if (rst) b = 0;
    else if (load) b = int'(load_val) & mx;
    else if (en) begin
      if (up) begin
        if (b == mx) begin tc = 1'b1; b = wrap ? 0 : mx; end
        else b = b + 1;
      end else begin
        if (b == 0) begin tc = 1'b1; b = wrap ? mx : 0; end
        else b = b - 1;
      end
    end
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    model(m3, e3, 3, 1'b1);
    model(m4, e4, 4, 1'b0);
    model(m8, e8, 8, 1'b1);
    model(m5w, e5w, 5, 1'b1);
    model(m5s, e5s, 5, 1'b0);
    @(posedge clk);
    #1;
    check("w3 bin", 32'(b3), 32'(m3));
    check("w3 gray", 32'(g3), 32'(gray_of(m3)));
    check("w3 tc", 32'(t3), 32'(e3));
    check("w4 bin", 32'(b4), 32'(m4));
    check("w4 gray", 32'(g4), 32'(gray_of(m4)));
    check("w4 tc", 32'(t4), 32'(e4));
    check("w8 bin", 32'(b8), 32'(m8));
    check("w8 gray", 32'(g8), 32'(gray_of(m8)));
    check("w8 tc", 32'(t8), 32'(e8));
    check("w5 wrap bin", 32'(b5w), 32'(m5w));
    check("w5 wrap gray", 32'(g5w), 32'(gray_of(m5w)));
    check("w5 wrap tc", 32'(t5w), 32'(e5w));
    check("w5 sat bin", 32'(b5s), 32'(m5s));
    check("w5 sat gray", 32'(g5s), 32'(gray_of(m5s)));
    check("w5 sat tc", 32'(t5s), 32'(e5s));
  endtask

  initial begin
    int gseq [8];
    logic [2:0] gprev;
    gseq = '{0, 1, 3, 2, 6, 7, 5, 4};
    m3 = 0; m4 = 0; m8 = 0; m5w = 0; m5s = 0;
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
    @(negedge clk);

    // Reset state.
    tick();
    check("reset bin", 32'(b3), 32'd0);
    check("reset gray", 32'(g3), 32'd0);
    check("reset tc", 32'(t3), 32'd0);

    // Count up through a full wrap.
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      gprev = g3;
      tick();
      check("up gray seq", 32'(g3), 32'(gseq[k % 8]));
      check("up bin seq", 32'(b3), 32'(k % 8));
      check("up tc", 32'(t3), (k == 8) ? 32'd1 : 32'd0);
      check("up one bit", 32'($countones(gprev ^ g3)), 32'd1);
    end

    // Count down from zero wraps to MAX.
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    check("down wrap bin", 32'(b3), 32'd7);
    check("down wrap gray", 32'(g3), 32'd4);
    check("down wrap tc", 32'(t3), 32'd1);
    tick();
    check("down next bin", 32'(b3), 32'd6);
    check("down next gray", 32'(g3), 32'd5);
    check("down next tc", 32'(t3), 32'd0);

    // Load beats enable.
    load = 1'b1; load_val = 32'd5; en = 1'b1; up = 1'b1;
    tick();
    check("load bin", 32'(b3), 32'd5);
    check("load gray", 32'(g3), 32'd7);
    check("load tc", 32'(t3), 32'd0);
    load = 1'b0;
    tick();
    check("post load bin", 32'(b3), 32'd6);
    check("post load gray", 32'(g3), 32'd5);

    // Saturation on the 4-bit non-wrapping instance.
    load = 1'b1; load_val = 32'd15; en = 1'b0;
    tick();
    check("load limit no tc", 32'(t4), 32'd0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sat bin", 32'(b4), 32'd15);
      check("sat gray", 32'(g4), 32'd8);
      check("sat tc", 32'(t4), 32'd1);
    end
    up = 1'b0;
    tick();
    check("unsat bin", 32'(b4), 32'd14);
    check("unsat gray", 32'(g4), 32'd9);
    check("unsat tc", 32'(t4), 32'd0);

    // Reset mid-count overrides a simultaneous load.
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 32'h5A; k++) tick();
    check("mid count bin", 32'(b8), 32'h5A);
    rst = 1'b1; load = 1'b1; load_val = 32'hFF;
    tick();
    check("mid rst bin", 32'(b8), 32'h00);
    check("mid rst gray", 32'(g8), 32'h00);
    check("mid rst tc", 32'(t8), 32'd0);
    rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    check("after rst bin", 32'(b8), 32'h01);
    check("after rst gray", 32'(g8), 32'h01);

    // Random soak across all instances.
    for (int k = 0; k < 10000; k++) begin
      rst      = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 1) == 1);
      load_val = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
